// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, register map
// addresses and the default number of maskable lines.
package intc_pkg;

    localparam int DEFAULT_NUM_IRQ = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_PEND  = 2'd1;
    localparam logic [1:0] ADDR_CAUSE = 2'd2;
    localparam logic [1:0] ADDR_STAT  = 2'd3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge pulse generator for one
// asynchronous request line.
module sync_edge_detect (
    input  logic CLK,
    input  logic RST_N,
    input  logic async_i,
    output logic pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] arm_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 2'd0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    // Suppress pulses until prev_q holds a real sample, so a line already high at reset release is not seen as an edge.
    assign pulse_o = sync2_q & ~prev_q & (arm_q == 2'd3);

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: edge-triggered pending bits, mask register,
// IDLE/REQ/SERVICE handshake with the CPU and a separate non-maskable request.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
    parameter int IDW     = 3
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               NMI_IN,
    input  logic               WEn,
    input  logic [1:0]         Address,
    input  logic [31:0]        Wdata,
    output logic [31:0]        Rdata,
    output logic               INT,
    output logic               NMI,
    input  logic               INTA,
    input  logic               NMIA,
    input  logic               EOI,
    output logic [IDW-1:0]     CAUSE
);

    logic [NUM_IRQ-1:0] irq_edge;
    logic               nmi_edge;

    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]     cause_q, cause_d;
    state_t             state_q, state_d;
    logic               nmi_q, nmi_d;

    logic [NUM_IRQ-1:0] active;
    logic [IDW-1:0]     lowest_idx;
    logic               unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
            sync_edge_detect u_sync (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .async_i (IRQ[gi]),
                .pulse_o (irq_edge[gi])
            );
        end
    endgenerate

    sync_edge_detect u_nmi_sync (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .async_i (NMI_IN),
        .pulse_o (nmi_edge)
    );

    assign active       = pending_q & mask_q;
    assign unused_wdata = ^Wdata[31:NUM_IRQ];

    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                lowest_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        mask_d    = mask_q;
        pending_d = pending_q;
        cause_d   = cause_q;
        state_d   = state_q;
        nmi_d     = nmi_q;

        if (WEn && Address == ADDR_MASK) begin
            mask_d = Wdata[NUM_IRQ-1:0];
        end
        if (WEn && Address == ADDR_PEND) begin
            pending_d = pending_d & ~Wdata[NUM_IRQ-1:0];
        end
        if (state_q == ST_REQ && INTA) begin
            pending_d = pending_d & ~(NUM_IRQ'(1) << cause_q);
        end
        // New edges are ORed in last so they survive a same-cycle clear.
        pending_d = pending_d | irq_edge;

        case (state_q)
            ST_IDLE: begin
                if (active != '0) begin
                    state_d = ST_REQ;
                    cause_d = lowest_idx;
                end
            end
            ST_REQ: begin
                if (INTA) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (EOI) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (nmi_edge) begin
            nmi_d = 1'b1;
        end else if (NMIA) begin
            nmi_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mask_q    <= '0;
            pending_q <= '0;
            cause_q   <= '0;
            state_q   <= ST_IDLE;
            nmi_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
            state_q   <= state_d;
            nmi_q     <= nmi_d;
        end
    end

    always_comb begin
        Rdata = '0;
        case (Address)
            ADDR_MASK:  Rdata = 32'(mask_q);
            ADDR_PEND:  Rdata = 32'(pending_q);
            ADDR_CAUSE: Rdata = 32'(cause_q);
            ADDR_STAT:  Rdata = {29'd0, nmi_q, state_q};
            default:    Rdata = '0;
        endcase
    end

    assign INT   = (state_q == ST_REQ);
    assign NMI   = nmi_q;
    assign CAUSE = cause_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: register table, directed
// handshake sequences and a randomized run against a behavioural model.
module tb_interrupt_controller;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  IRQ = 8'h00;
    logic        NMI_IN = 1'b0;
    logic        WEn = 1'b0;
    logic [1:0]  Address = 2'd0;
    logic [31:0] Wdata = 32'd0;
    logic [31:0] Rdata;
    logic        INT;
    logic        NMI;
    logic        INTA = 1'b0;
    logic        NMIA = 1'b0;
    logic        EOI = 1'b0;
    logic [2:0]  CAUSE;

    interrupt_controller #(.NUM_IRQ(8), .IDW(3)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IRQ     (IRQ),
        .NMI_IN  (NMI_IN),
        .WEn     (WEn),
        .Address (Address),
        .Wdata   (Wdata),
        .Rdata   (Rdata),
        .INT     (INT),
        .NMI     (NMI),
        .INTA    (INTA),
        .NMIA    (NMIA),
        .EOI     (EOI),
        .CAUSE   (CAUSE)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: state 0=IDLE 1=REQ 2=SERVICE
    bit [7:0] m_mask, m_pend;
    int       m_state, m_cause;
    bit       m_nmi;
    bit [7:0] irq_hist[$];
    bit       nmi_hist[$];

    typedef struct {
        logic        wen;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_state = 0; m_cause = 0; m_nmi = 0;
        irq_hist.delete();
        nmi_hist.delete();
    endtask

    // A request is a line seen low then high in consecutive synchronised samples.
    task automatic model_clock();
        bit [7:0] rises;
        bit       nrise;
        bit [7:0] pend_n;
        rises = 0;
        nrise = 0;
        if (irq_hist.size() >= 3) begin
            rises = irq_hist[1] & ~irq_hist[0];
            nrise = nmi_hist[1] & ~nmi_hist[0];
        end
        irq_hist.push_back(IRQ);
        nmi_hist.push_back(NMI_IN);
        if (irq_hist.size() > 3) begin
            void'(irq_hist.pop_front());
            void'(nmi_hist.pop_front());
        end
        pend_n = m_pend;
        if (WEn && Address == 2'd1) pend_n &= ~Wdata[7:0];
        if (m_state == 1 && INTA) pend_n[m_cause] = 1'b0;
        pend_n |= rises;
        case (m_state)
            0: if ((m_pend & m_mask) != 0) begin
                   m_state = 1;
                   m_cause = lowest(m_pend & m_mask);
               end
            1: if (INTA) m_state = 2;
            default: if (EOI) m_state = 0;
        endcase
        if (WEn && Address == 2'd0) m_mask = Wdata[7:0];
        m_pend = pend_n;
        if (nrise) m_nmi = 1;
        else if (NMIA) m_nmi = 0;
    endtask

    function automatic logic [31:0] exp_rdata();
        case (Address)
            2'd0:    return {24'd0, m_mask};
            2'd1:    return {24'd0, m_pend};
            2'd2:    return m_cause;
            default: return {29'd0, m_nmi, 2'(m_state)};
        endcase
    endfunction

    task automatic cyc();
        @(posedge CLK);
        if (RST_N) model_clock();
        #1;
        chk("INT", INT, m_state == 1);
        chk("NMI", NMI, m_nmi);
        chk("CAUSE", CAUSE, m_cause);
        chk("Rdata", Rdata, exp_rdata());
        WEn = 0; INTA = 0; NMIA = 0; EOI = 0;
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic reset_dut();
        RST_N = 0;
        model_reset();
        #1;
        chk("rst_INT", INT, 0);
        chk("rst_NMI", NMI, 0);
        cycles(2);
        RST_N = 1;
        cycles(4);
    endtask

    initial begin
        tbl[0] = '{1'b0, 2'd0, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 2'd1, 32'h0,        32'h0};
        tbl[2] = '{1'b0, 2'd2, 32'h0,        32'h0};
        tbl[3] = '{1'b0, 2'd3, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 2'd0, 32'hA5,       32'hA5};
        tbl[5] = '{1'b1, 2'd0, 32'hFFFFFF3C, 32'h3C};
        tbl[6] = '{1'b1, 2'd1, 32'hFF,       32'h0};
        tbl[7] = '{1'b1, 2'd2, 32'h7,        32'h0};
        tbl[8] = '{1'b1, 2'd3, 32'hFF,       32'h0};
        tbl[9] = '{1'b0, 2'd0, 32'h0,        32'h3C};

        model_reset();
        #2;
        chk("por_INT", INT, 0);
        Address = 2'd3;
        #1;
        chk("por_STATUS", Rdata, 0);
        reset_dut();

        for (int i = 0; i < 10; i++) begin
            WEn = tbl[i].wen; Address = tbl[i].addr; Wdata = tbl[i].wdata;
            cyc();
            chk($sformatf("tbl%0d", i), Rdata, tbl[i].exp_rdata);
        end

        // Lowest-priority path: single line through the full handshake
        reset_dut();
        WEn = 1; Address = 2'd0; Wdata = 32'hFF; cyc();
        IRQ[5] = 1; Address = 2'd1;
        cycles(2);
        chk("s33_pend_e2", Rdata, 32'h00);
        cyc();
        chk("s33_pend_e3", Rdata, 32'h20);
        chk("s33_int_e3", INT, 0);
        cyc();
        chk("s33_int_e4", INT, 1);
        chk("s33_cause", CAUSE, 5);
        INTA = 1; cyc();
        chk("s33_int_ack", INT, 0);
        chk("s33_pend_ack", Rdata, 32'h00);
        Address = 2'd3; #1;
        chk("s33_state", Rdata[1:0], 2);

        // Two simultaneous lines: lowest first, the other after EOI
        IRQ = 0; reset_dut();
        WEn = 1; Address = 2'd0; Wdata = 32'hFF; cyc();
        IRQ = 8'h44; cycles(4);
        chk("s34_int", INT, 1);
        chk("s34_cause", CAUSE, 2);
        INTA = 1; cyc();
        EOI = 1; cyc();
        chk("s34_int_idle", INT, 0);
        cyc();
        chk("s34_int2", INT, 1);
        chk("s34_cause2", CAUSE, 6);

        // Masked line becomes visible once unmasked
        IRQ = 0; reset_dut();
        Address = 2'd1; IRQ[3] = 1; cycles(3);
        chk("s35_pend", Rdata, 32'h08);
        cyc();
        chk("s35_int_masked", INT, 0);
        WEn = 1; Address = 2'd0; Wdata = 32'h08; cyc();
        chk("s35_int_wr", INT, 0);
        cyc();
        chk("s35_int", INT, 1);
        chk("s35_cause", CAUSE, 3);

        // NMI during SERVICE
        IRQ = 0; reset_dut();
        WEn = 1; Address = 2'd0; Wdata = 32'hFF; cyc();
        IRQ[0] = 1; cycles(4);
        chk("s36_int", INT, 1);
        INTA = 1; cyc();
        Address = 2'd3; NMI_IN = 1; cycles(2);
        chk("s36_nmi_e2", NMI, 0);
        cyc();
        chk("s36_nmi_e3", NMI, 1);
        chk("s36_int", INT, 0);
        chk("s36_status", Rdata, 32'h6);
        NMIA = 1; cyc();
        chk("s36_nmi_ack", NMI, 0);

        // Committed request survives mask/W1C; async reset drops it immediately
        IRQ = 0; NMI_IN = 0; reset_dut();
        WEn = 1; Address = 2'd0; Wdata = 32'hFF; cyc();
        IRQ[7] = 1; NMI_IN = 1; cycles(4);
        chk("s37_int", INT, 1);
        chk("s37_cause", CAUSE, 7);
        chk("s37_nmi", NMI, 1);
        WEn = 1; Address = 2'd0; Wdata = 32'h0; cyc();
        chk("s37_int_mask0", INT, 1);
        WEn = 1; Address = 2'd1; Wdata = 32'h80; cyc();
        chk("s37_int_w1c", INT, 1);
        #2;
        RST_N = 0; model_reset(); Address = 2'd3;
        #1;
        chk("s37_int_rst", INT, 0);
        chk("s37_nmi_rst", NMI, 0);
        chk("s37_status_rst", Rdata, 0);
        cycles(2);
        RST_N = 1;
        Address = 2'd1;
        cycles(8);
        chk("s37_int_held", INT, 0);
        chk("s37_pend_held", Rdata, 0);

        // Same-cycle edge and W1C: set wins
        IRQ = 0; NMI_IN = 0; reset_dut();
        IRQ[1] = 1; cycles(2);
        WEn = 1; Address = 2'd1; Wdata = 32'h2; cyc();
        chk("s38_set_wins", Rdata, 32'h02);
        WEn = 1; Address = 2'd1; Wdata = 32'h2; cyc();
        chk("s38_w1c", Rdata, 32'h00);

        // Randomized run against the model
        IRQ = 0; reset_dut();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) IRQ[$urandom_range(0, 7)] = ~IRQ[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) NMI_IN = ~NMI_IN;
            WEn     = ($urandom_range(0, 5) == 0);
            Address = 2'($urandom_range(0, 3));
            Wdata   = $urandom;
            INTA    = ($urandom_range(0, 3) == 0);
            EOI     = ($urandom_range(0, 3) == 0);
            NMIA    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) begin
                WEn = 0; INTA = 0; EOI = 0; NMIA = 0;
                reset_dut();
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
